// File: rtl/ones_count_arbiter.sv
// Round-robin arbiter that feeds one requester word at a time into a shared
// ones-counter engine and returns the count (or a timeout error) to that requester.
//
// state | meaning
// IDLE  | no service in progress; Req sampled, winner latched
// ISSUE | EngStart pulse, wait timer cleared
// WAIT  | waiting for EngDone or timeout
// RESP  | Ack to the served requester, Result/Err valid
module ones_count_arbiter #(
    parameter int bitInput = 8,
    parameter int bitcount = 4,
    parameter int NREQ     = 4,
    parameter int TIMEOUT  = 32
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic [NREQ-1:0]          Req,
    input  logic [NREQ*bitInput-1:0] DataIn,
    output logic [NREQ-1:0]          Grant,
    output logic [NREQ-1:0]          Ack,
    output logic [bitcount-1:0]      Result,
    output logic                     Err,
    output logic                     Busy,
    output logic                     EngStart,
    output logic [bitInput-1:0]      EngData,
    input  logic                     EngDone,
    input  logic [bitcount-1:0]      EngCount
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST   = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       idx;
    logic [PW-1:0]       win;
    logic [PW-1:0]       cand;
    logic                win_found;
    logic [bitInput-1:0] word;
    logic [bitInput-1:0] word_sel;
    logic [TW-1:0]       timer;
    logic                timed_out;
    logic [NREQ-1:0]     idx_onehot;

    // Search starts just past the last served requester so it goes to the back of the line.
    always_comb begin
        win       = ptr;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (!win_found && Req[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                word_sel = DataIn[i*bitInput +: bitInput];
            end
        end
    end

    always_comb begin
        idx_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx_onehot[i] = (idx == PW'(i));
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        timed_out  = 1'b0;
        Busy       = 1'b0;
        EngStart   = 1'b0;
        Grant      = '0;
        Ack        = '0;
        EngData    = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                Busy       = 1'b1;
                EngStart   = 1'b1;
                Grant      = idx_onehot;
                EngData    = word;
                state_next = WAIT;
            end
            WAIT: begin
                Busy    = 1'b1;
                Grant   = idx_onehot;
                EngData = word;
                // A completion landing on the last timer count wins over the timeout.
                if (EngDone) begin
                    state_next = RESP;
                end else if (timer == TLAST) begin
                    timed_out  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                Busy       = 1'b1;
                Grant      = idx_onehot;
                Ack        = idx_onehot;
                EngData    = word;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            ptr    <= PTR_RST;
            idx    <= '0;
            word   <= '0;
            timer  <= '0;
            Result <= '0;
            Err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        idx  <= win;
                        word <= word_sel;
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    if (EngDone) begin
                        Result <= EngCount;
                        Err    <= 1'b0;
                    end else if (timed_out) begin
                        Result <= '0;
                        Err    <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: ptr <= idx;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ones_count_arbiter.sv
// Bench for ones_count_arbiter: engine model plus a round-robin reference that
// predicts winner, count, error and timing for directed and random services.
module tb_ones_count_arbiter;

    localparam int BI = 8;
    localparam int BC = 4;
    localparam int NR = 4;
    localparam int TO = 32;

    logic              CLK = 1'b0;
    logic              Reset = 1'b0;
    logic [NR-1:0]     Req = '0;
    logic [NR*BI-1:0]  DataIn = '0;
    logic [NR-1:0]     Grant;
    logic [NR-1:0]     Ack;
    logic [BC-1:0]     Result;
    logic              Err;
    logic              Busy;
    logic              EngStart;
    logic [BI-1:0]     EngData;
    logic              EngDone = 1'b0;
    logic [BC-1:0]     EngCount = '0;

    int checks = 0;
    int passed = 0;

    logic [BI-1:0] words [NR];
    int            m_ptr = NR - 1;
    logic [BC-1:0] m_result = '0;
    logic          m_err = 1'b0;

    ones_count_arbiter #(
        .bitInput(BI), .bitcount(BC), .NREQ(NR), .TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .Reset(Reset), .Req(Req), .DataIn(DataIn),
        .Grant(Grant), .Ack(Ack), .Result(Result), .Err(Err), .Busy(Busy),
        .EngStart(EngStart), .EngData(EngData),
        .EngDone(EngDone), .EngCount(EngCount)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pack_data();
        DataIn = {words[3], words[2], words[1], words[0]};
    endtask

    task automatic rand_words();
        for (int i = 0; i < NR; i++) words[i] = BI'($urandom);
        pack_data();
    endtask

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] v;
        v = 1;
        return v << i;
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] r, input int p);
        for (int k = 1; k <= NR; k++) begin
            int c;
            c = (p + k) % NR;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic do_reset();
        Reset = 1'b0;
        step();
        step();
        Reset = 1'b1;
        m_ptr = NR - 1;
        m_result = '0;
        m_err = 1'b0;
    endtask

    // One full service: waits for EngStart, plays the engine, checks the response.
    task automatic run_one(input int delay, input bit tmo, input bit disturb, output int who);
        bit            seen;
        int            w;
        int            cyc;
        logic [BI-1:0] wd;
        logic [BC-1:0] exp_res;
        logic          exp_err;
        seen = 1'b0;
        who = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (EngStart) seen = 1'b1;
            else step();
        end
        checks++;
        if (!seen) begin
            $display("FAIL start_seen: EngStart=0 after 20 cycles, required 1");
            return;
        end
        passed++;
        w = rr_pick(Req, m_ptr);
        wd = words[w];

        checks++;
        if (EngData !== wd) $display("FAIL engdata_issue: got %h required %h", EngData, wd);
        else passed++;
        checks++;
        if (Grant !== oh(w) || Busy !== 1'b1)
            $display("FAIL grant_issue: Grant=%b Busy=%b required Grant=%b Busy=1", Grant, Busy, oh(w));
        else passed++;

        if (!tmo) begin
            for (int i = 0; i < delay; i++) begin
                step();
                if (disturb && i == 0) begin
                    words[w] = ~wd;
                    pack_data();
                    Req = '0;
                end
                checks++;
                if (Ack !== '0) $display("FAIL early_ack: got %b required 0000", Ack);
                else passed++;
            end
            checks++;
            if (EngData !== wd || Grant !== oh(w))
                $display("FAIL engdata_wait: EngData=%h Grant=%b required %h %b", EngData, Grant, wd, oh(w));
            else passed++;
            exp_res = BC'($countones(wd));
            exp_err = 1'b0;
            EngDone = 1'b1;
            EngCount = exp_res;
            step();
            EngDone = 1'b0;
            EngCount = BC'($urandom);
        end else begin
            cyc = 0;
            while (Ack === '0 && cyc < TO + 10) begin
                step();
                cyc++;
            end
            checks++;
            if (cyc != TO + 1) $display("FAIL timeout_latency: got %0d cycles required %0d", cyc, TO + 1);
            else passed++;
            exp_res = '0;
            exp_err = 1'b1;
        end

        checks++;
        if (Ack !== oh(w) || Grant !== oh(w))
            $display("FAIL ack: Ack=%b Grant=%b required %b", Ack, Grant, oh(w));
        else passed++;
        checks++;
        if (Result !== exp_res || Err !== exp_err)
            $display("FAIL result: Result=%0d Err=%b required %0d %b", Result, Err, exp_res, exp_err);
        else passed++;

        m_ptr = w;
        m_result = exp_res;
        m_err = exp_err;
        who = w;
        step();
        checks++;
        if (Ack !== '0 || Busy !== 1'b0 || Result !== m_result || Err !== m_err)
            $display("FAIL after_resp: Ack=%b Busy=%b Result=%0d Err=%b required 0000 0 %0d %b",
                     Ack, Busy, Result, Err, m_result, m_err);
        else passed++;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Req = '0;
        rand_words();
        step();
        step();
        checks++;
        if (Grant !== '0 || Ack !== '0 || Result !== '0 || Err !== 1'b0 || Busy !== 1'b0
            || EngStart !== 1'b0 || EngData !== '0)
            $display("FAIL reset_outputs: G=%b A=%b R=%0d E=%b B=%b S=%b D=%h required all zero",
                     Grant, Ack, Result, Err, Busy, EngStart, EngData);
        else passed++;
        Reset = 1'b1;
        step();
        step();
        checks++;
        if (Grant !== '0 || Busy !== 1'b0 || EngStart !== 1'b0 || EngData !== '0)
            $display("FAIL idle_outputs: G=%b B=%b S=%b D=%h required all zero", Grant, Busy, EngStart, EngData);
        else passed++;
        m_ptr = NR - 1;
        m_result = '0;
        m_err = 1'b0;
    endtask

    task automatic test_single();
        int who;
        do_reset();
        rand_words();
        words[0] = 8'hB5;
        pack_data();
        Req = 4'b0001;
        run_one(3, 1'b0, 1'b0, who);
        checks++;
        if (who != 0 || Result !== 4'd5)
            $display("FAIL single: who=%0d Result=%0d required 0 5", who, Result);
        else passed++;
        Req = '0;
    endtask

    task automatic test_round_robin();
        int who;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        Req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            rand_words();
            run_one(int'($urandom_range(1, 4)), 1'b0, 1'b0, who);
            checks++;
            if (who != exp_order[n]) $display("FAIL rr_order_%0d: got %0d required %0d", n, who, exp_order[n]);
            else passed++;
        end
        Req = '0;
    endtask

    task automatic test_timeout();
        int who;
        rand_words();
        Req = 4'b0100;
        run_one(0, 1'b1, 1'b0, who);
        checks++;
        if (who != 2) $display("FAIL timeout_who: got %0d required 2", who);
        else passed++;
        rand_words();
        Req = 4'b0010;
        run_one(TO, 1'b0, 1'b0, who);
        checks++;
        if (who != 1 || Err !== 1'b0) $display("FAIL done_at_limit: who=%0d Err=%b required 1 0", who, Err);
        else passed++;
        Req = '0;
    endtask

    task automatic test_reset_mid_wait();
        int who;
        bit seen;
        rand_words();
        Req = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (EngStart) seen = 1'b1;
            else step();
        end
        step();
        step();
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        checks++;
        if (!seen || Grant !== '0 || Ack !== '0 || Result !== '0 || Err !== 1'b0 || Busy !== 1'b0
            || EngStart !== 1'b0 || EngData !== '0)
            $display("FAIL reset_mid_wait: seen=%b G=%b A=%b R=%0d E=%b B=%b D=%h required all zero",
                     seen, Grant, Ack, Result, Err, Busy, EngData);
        else passed++;
        m_ptr = NR - 1;
        m_result = '0;
        m_err = 1'b0;
        run_one(2, 1'b0, 1'b0, who);
        checks++;
        if (who != 0) $display("FAIL reserve_after_reset: got %0d required 0", who);
        else passed++;
        Req = '0;
    endtask

    task automatic test_data_stability();
        int who;
        rand_words();
        Req = 4'b1000;
        run_one(4, 1'b0, 1'b1, who);
        checks++;
        if (who != 3) $display("FAIL stability_who: got %0d required 3", who);
        else passed++;
        Req = '0;
    endtask

    task automatic test_spurious_done();
        Req = '0;
        step();
        step();
        EngDone = 1'b1;
        EngCount = ~m_result;
        step();
        EngDone = 1'b0;
        step();
        checks++;
        if (Ack !== '0 || Busy !== 1'b0 || Grant !== '0 || EngStart !== 1'b0 || Result !== m_result)
            $display("FAIL spurious_done: A=%b B=%b G=%b S=%b R=%0d required 0 0 0 0 %0d",
                     Ack, Busy, Grant, EngStart, Result, m_result);
        else passed++;
    endtask

    task automatic test_random();
        int who;
        bit tmo;
        for (int n = 0; n < 40; n++) begin
            rand_words();
            Req = NR'($urandom_range(1, (1 << NR) - 1));
            tmo = ($urandom_range(0, 7) == 0);
            run_one(int'($urandom_range(1, 6)), tmo, (!tmo && $urandom_range(0, 3) == 0), who);
        end
        Req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_mid_wait();
        test_data_stability();
        test_spurious_done();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
